ahbl_mst_arb: RTL
=================

Name: ahbl_mst_arb

Overview:
- Round-robin arbiter/sequencer that shares one AHB-Lite master port among NUM_REQ simple valid/ready requesters.
- Issues SINGLE, NONSEQ transfers with pipelined address and data phases, and returns read data and error status to the owning requester.
- Sits between on-chip initiators (DMA, debug, test engines) and the ahbl_mst_ifc-style master bus.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- AHBL_ADDR_WIDTH, 32, haddr width.
- AHBL_WDATA_WIDTH, 32, hwdata/req_wdata width.
- AHBL_RDATA_WIDTH, 32, hrdata/rsp_rdata width.

Ports:
- hclk  in  1  clock.
- hresetn  in  1  asynchronous active-low reset.
- req_vld  in  NUM_REQ  request valid per requester.
- req_rdy  out  NUM_REQ  request accepted; the address phase completes this cycle.
- req_write  in  NUM_REQ  1 = write.
- req_size  in  NUM_REQ*3  hsize per requester.
- req_addr  in  NUM_REQ*AHBL_ADDR_WIDTH  address per requester.
- req_wdata  in  NUM_REQ*AHBL_WDATA_WIDTH  write data per requester.
- rsp_vld  out  NUM_REQ  one-cycle response pulse.
- rsp_err  out  1  response was ERROR.
- rsp_rdata  out  AHBL_RDATA_WIDTH  read data (0 for writes).
- haddr  out  AHBL_ADDR_WIDTH  AHB address.
- htrans  out  2  IDLE=00, NONSEQ=10 only.
- hwrite  out  1  AHB write.
- hsize  out  3  AHB size.
- hburst  out  3  constant SINGLE (000).
- hprot  out  4  constant 4'b0011.
- hmastlock  out  1  constant 0.
- hwdata  out  AHBL_WDATA_WIDTH  registered write data.
- hready  in  1  bus ready.
- hresp  in  2  OKAY=00, ERROR=01.
- hrdata  in  AHBL_RDATA_WIDTH  read data.

Behaviour:
- Requester rule: once req_vld[i]=1, the requester holds req_vld and its payload stable until req_rdy[i]=1.
- Grant selection:
  - If no address phase is pending, grant the first requester with req_vld=1, searching from rr_ptr+1 modulo NUM_REQ.
  - rr_ptr resets to NUM_REQ-1, so requester 0 has first priority.
- Address phase:
  - With a grant: htrans=NONSEQ; haddr, hwrite and hsize come combinationally from the granted requester.
  - With no grant: htrans=IDLE and haddr/hwrite/hsize are 0.
- Acceptance: when htrans=NONSEQ and hready=1, then req_rdy[grant]=1 and rr_ptr<=grant.
  - The data-phase registers load: dp_vld=1, dp_idx, dp_write.
  - hwdata<=req_wdata on writes; hwdata holds its value on reads.
  - req_rdy is combinational on hready.
- Stall: NONSEQ with hready=0 sets addr_pend. While addr_pend=1 the grant is frozen, so haddr, htrans, hwrite and hsize stay stable. addr_pend clears on acceptance.
- Data phase completion: when dp_vld=1 and hready=1, on the next cycle:
  - rsp_vld[dp_idx]=1 for exactly one cycle;
  - rsp_err=(hresp==ERROR);
  - rsp_rdata=hrdata for reads, 0 for writes.
  - dp_vld clears unless a new transfer is accepted in the same cycle.
- Back-to-back: a new acceptance may coincide with a data-phase completion, giving one transfer per cycle at zero wait states. Read latency from req_rdy to rsp_vld is 2 cycles at zero wait states.
- ERROR first cycle (dp_vld=1, hresp=ERROR, hready=0):
  - force htrans=IDLE and cancel the pending address phase;
  - clear addr_pend; no req_rdy is asserted;
  - the grant is re-evaluated in the following cycle.
- ERROR second cycle (hready=1): completes as normal with rsp_err=1. A new NONSEQ may be issued in that cycle.
- Simultaneous events: rsp_vld for the old transfer and req_rdy for a new one may assert together, for the same or different requesters.
- Reset values: req_rdy=0, rsp_vld=0, rsp_err=0, rsp_rdata=0, hwdata=0, htrans=IDLE, haddr=0, hwrite=0, hsize=0, dp_vld=0, addr_pend=0, rr_ptr=NUM_REQ-1.
- Reset mid-transfer: all state is dropped immediately; no response is returned for an in-flight transfer.
- Unsupported hresp codes 10/11 are treated as ERROR.

Decomposition:
- Shared package ahbl_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ;
  - HBURST_SINGLE..INCR16;
  - HSIZE_BYTE/HALF/WORD;
  - HRESP_OKAY/ERROR;
  - HPROT_DEFAULT=4'b0011.
- Sub-module ahbl_rr_arb: a purely combinational round-robin picker. Inputs are req vector and ptr; outputs are grant index and grant valid.
- The top level holds the pending/data-phase registers and the bus muxing.

Test Plan:
- Single read: req0 reads 0x1000, hrdata=0xDEADBEEF, zero wait states -> req_rdy[0] at T0, HADDR=0x1000 NONSEQ at T0, rsp_vld[0] at T2 with rsp_rdata=0xDEADBEEF and rsp_err=0.
- Round-robin: req0 and req1 both continuously valid -> grants alternate 0,1,0,1 and haddr alternates between their addresses every cycle.
- Wait states: write by req1 to 0x20, wdata 0x55AA, hready low 3 cycles during the address phase -> haddr/htrans stable 3 cycles with no grant switch even if req0 asserts; hwdata=0x55AA in the data phase.
- Error cancel: read by req0 gets 2-cycle ERROR while req1 is pending NONSEQ -> htrans=IDLE in error cycle 1, rsp_vld[0] with rsp_err=1, req1 reissued and accepted afterwards.
- Pipelined mixed traffic: write then read back-to-back from req0 with 1 wait state on the write data phase -> hwdata held, read address stalled and stable, responses in order with rsp_rdata=0 for the write.
- Reset: assert hresetn low during a stalled data phase -> all outputs at reset values immediately, no rsp_vld after release.

Source files
------------

// File: rtl/ahbl_pkg.sv
// ahbl_pkg
// Shared AHB-Lite encodings used by the master-side arbiter and its helpers.
// Holds the HTRANS, HBURST, HSIZE, HRESP and HPROT codes, plus a small
// helper that classifies a response code.
package ahbl_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

   // Any code other than OKAY (including the reserved 10/11) counts as ERROR.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp != HRESP_OKAY;
   endfunction

endpackage

// File: rtl/ahbl_rr_arb.sv
// ahbl_rr_arb
// Purely combinational round-robin picker.
// Ports:
//   req      : request vector, one bit per requester
//   ptr      : index of the requester granted most recently
//   gnt_idx  : first requesting index found searching from ptr+1 (mod NUM_REQ)
//   gnt_vld  : at least one requester is asking
module ahbl_rr_arb #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_vld
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      // Scan from the farthest candidate to the nearest one so the last hit,
      // which overrides the earlier ones, is the closest after ptr.
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
         if (req[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

endmodule

// File: rtl/ahbl_mst_arb.sv
// ahbl_mst_arb
// Round-robin sequencer sharing one AHB-Lite master port among NUM_REQ
// valid/ready requesters. Issues SINGLE NONSEQ transfers with pipelined
// address and data phases and routes the response back to the owner.
// Ports:
//   hclk, hresetn          : clock, asynchronous active-low reset
//   req_vld/req_rdy        : per-requester handshake (rdy = address phase done)
//   req_write/size/addr/wdata : per-requester payload, packed by index
//   rsp_vld/err/rdata      : one-cycle response to the owning requester
//   haddr..hmastlock,hwdata: AHB-Lite master outputs
//   hready, hresp, hrdata  : AHB-Lite slave-side inputs
module ahbl_mst_arb
   import ahbl_pkg::*;
#(
   parameter int NUM_REQ          = 2,
   parameter int AHBL_ADDR_WIDTH  = 32,
   parameter int AHBL_WDATA_WIDTH = 32,
   parameter int AHBL_RDATA_WIDTH = 32
) (
   input  logic                                  hclk,
   input  logic                                  hresetn,
   input  logic [NUM_REQ-1:0]                    req_vld,
   output logic [NUM_REQ-1:0]                    req_rdy,
   input  logic [NUM_REQ-1:0]                    req_write,
   input  logic [NUM_REQ*3-1:0]                  req_size,
   input  logic [NUM_REQ*AHBL_ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*AHBL_WDATA_WIDTH-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]                    rsp_vld,
   output logic                                  rsp_err,
   output logic [AHBL_RDATA_WIDTH-1:0]           rsp_rdata,
   output logic [AHBL_ADDR_WIDTH-1:0]            haddr,
   output logic [1:0]                            htrans,
   output logic                                  hwrite,
   output logic [2:0]                            hsize,
   output logic [2:0]                            hburst,
   output logic [3:0]                            hprot,
   output logic                                  hmastlock,
   output logic [AHBL_WDATA_WIDTH-1:0]           hwdata,
   input  logic                                  hready,
   input  logic [1:0]                            hresp,
   input  logic [AHBL_RDATA_WIDTH-1:0]           hrdata
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int AW    = AHBL_ADDR_WIDTH;
   localparam int WW    = AHBL_WDATA_WIDTH;
   localparam int RW    = AHBL_RDATA_WIDTH;

   logic [IDX_W-1:0]   rr_ptr_reg;
   logic [IDX_W-1:0]   pend_idx_reg;
   logic               addr_pend_reg;
   logic               dp_vld_reg;
   logic [IDX_W-1:0]   dp_idx_reg;
   logic               dp_write_reg;
   logic [WW-1:0]      hwdata_reg;
   logic [NUM_REQ-1:0] rsp_vld_reg;
   logic [NUM_REQ-1:0] rsp_vld_next;
   logic               rsp_err_reg;
   logic [RW-1:0]      rsp_rdata_reg;

   logic [IDX_W-1:0]   arb_idx;
   logic               arb_vld;
   logic [IDX_W-1:0]   grant_idx;
   logic               grant_vld;
   logic               err_first;
   logic               issue;
   logic               accept;
   logic               dp_done;

   logic [AW-1:0]      addr_arr  [NUM_REQ];
   logic [2:0]         size_arr  [NUM_REQ];
   logic [WW-1:0]      wdata_arr [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign addr_arr[gi]     = req_addr[gi*AW +: AW];
         assign size_arr[gi]     = req_size[gi*3 +: 3];
         assign wdata_arr[gi]    = req_wdata[gi*WW +: WW];
         assign req_rdy[gi]      = accept && (grant_idx == IDX_W'(gi));
         assign rsp_vld_next[gi] = dp_done && (dp_idx_reg == IDX_W'(gi));
      end
   endgenerate

   ahbl_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arb (
      .req     (req_vld),
      .ptr     (rr_ptr_reg),
      .gnt_idx (arb_idx),
      .gnt_vld (arb_vld)
   );

   // First cycle of a two-cycle ERROR: the address phase on the bus must be
   // withdrawn, so nothing is driven or accepted this cycle.
   assign err_first = dp_vld_reg && !hready && resp_is_err(hresp);

   // A stalled address phase keeps its original owner regardless of new requests.
   assign grant_idx = addr_pend_reg ? pend_idx_reg : arb_idx;
   assign grant_vld = addr_pend_reg || arb_vld;

   // Gated by hresetn so the combinational bus outputs read as IDLE/0 in reset.
   assign issue   = hresetn && grant_vld && !err_first;
   assign accept  = issue && hready;
   assign dp_done = dp_vld_reg && hready;

   assign htrans    = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign haddr     = issue ? addr_arr[grant_idx] : '0;
   assign hwrite    = issue && req_write[grant_idx];
   assign hsize     = issue ? size_arr[grant_idx] : '0;
   assign hburst    = HBURST_SINGLE;
   assign hprot     = HPROT_DEFAULT;
   assign hmastlock = 1'b0;
   assign hwdata    = hwdata_reg;
   assign rsp_vld   = rsp_vld_reg;
   assign rsp_err   = rsp_err_reg;
   assign rsp_rdata = rsp_rdata_reg;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         rr_ptr_reg    <= IDX_W'(NUM_REQ - 1);
         pend_idx_reg  <= '0;
         addr_pend_reg <= 1'b0;
         dp_vld_reg    <= 1'b0;
         dp_idx_reg    <= '0;
         dp_write_reg  <= 1'b0;
         hwdata_reg    <= '0;
         rsp_vld_reg   <= '0;
         rsp_err_reg   <= 1'b0;
         rsp_rdata_reg <= '0;
      end else begin
         rsp_vld_reg   <= rsp_vld_next;
         rsp_err_reg   <= dp_done && resp_is_err(hresp);
         rsp_rdata_reg <= (dp_done && !dp_write_reg) ? hrdata : '0;

         if (err_first) begin
            addr_pend_reg <= 1'b0;
         end else if (issue && !hready) begin
            addr_pend_reg <= 1'b1;
            pend_idx_reg  <= grant_idx;
         end else if (accept) begin
            addr_pend_reg <= 1'b0;
         end

         if (accept) begin
            rr_ptr_reg   <= grant_idx;
            dp_vld_reg   <= 1'b1;
            dp_idx_reg   <= grant_idx;
            dp_write_reg <= req_write[grant_idx];
            if (req_write[grant_idx]) begin
               hwdata_reg <= wdata_arr[grant_idx];
            end
         end else if (dp_done) begin
            dp_vld_reg <= 1'b0;
         end
      end
   end

endmodule
